layernorm_input_packer: RTL and testbench

- Upstream feeder for the 20-stage LayerNorm pipeline.
- Accepts a serial stream of Q5.10 elements on a valid/ready handshake and assembles them into one 16-element vector.
- Presents the vector in parallel with a single-cycle valid_out pulse, which drives the pipeline's valid_in and input_vector_0..15.
- The pipeline has no backpressure, so the packer issues at most one vector per N_ELEM accepted beats.

---
 rtl/layernorm_pkg.sv | 8 +
 rtl/layernorm_input_packer.sv | 91 +++++++++
 tb/tb_layernorm_input_packer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/layernorm_pkg.sv
// layernorm_pkg: shared Q5.10 constants, vector width and packer state encoding
package layernorm_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 10;
    localparam logic [DATA_W-1:0] ONE = 16'h0400;
    localparam int N_ELEM = 16;
    typedef enum logic {FILL, EMIT} pack_state_t;
endpackage

// File: rtl/layernorm_input_packer.sv
// layernorm_input_packer: packs a serial Q5.10 stream into 16-element vectors for the LayerNorm pipeline; LN_PACK_LAST_CHECK_EN enables s_last framing checks
module layernorm_input_packer
    import layernorm_pkg::*;
#(
    parameter int N_ELEM = layernorm_pkg::N_ELEM,
    parameter int DATA_W = layernorm_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_last,
    input  logic                     flush,
    output logic                     valid_out,
    output logic [N_ELEM*DATA_W-1:0] vector_out,
    output logic [CNT_W-1:0]         vec_count,
    output logic                     busy,
    output logic                     err_last_early,
    output logic                     err_last_missing
);
    localparam int IDX_W = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ELEM - 1);

    pack_state_t state;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] shadow [N_ELEM];
    logic [N_ELEM*DATA_W-1:0] next_vec;
    logic early_hit;

    assign s_ready   = rst_n && !flush;
    assign valid_out = (state == EMIT);
    assign busy      = (idx != '0);

`ifdef LN_PACK_LAST_CHECK_EN
    assign early_hit = s_last && (idx != LAST);

    // sticky framing errors, observed on every accepted beat
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_last_early   <= 1'b0;
            err_last_missing <= 1'b0;
        end else if (s_valid && s_ready) begin
            if (early_hit) err_last_early <= 1'b1;
            if (!s_last && idx == LAST) err_last_missing <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last      = s_last;
    assign early_hit        = 1'b0;
    assign err_last_early   = 1'b0;
    assign err_last_missing = 1'b0;
`endif

    // full vector as it will look once the incoming beat lands in the last slot
    always_comb begin
        next_vec = '0;
        for (int i = 0; i < N_ELEM; i++)
            next_vec[DATA_W*i +: DATA_W] = (i == N_ELEM - 1) ? s_data : shadow[i];
    end

    // fill/emit control: EMIT lasts one cycle and still accepts element 0 of the next vector
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FILL;
            idx        <= '0;
            vector_out <= '0;
            vec_count  <= '0;
            for (int i = 0; i < N_ELEM; i++) shadow[i] <= '0;
        end else begin
            state <= FILL;
            if (flush) begin
                idx <= '0;
            end else if (s_valid) begin
                shadow[idx] <= s_data;
                if (early_hit) begin
                    idx <= '0;
                end else if (idx == LAST) begin
                    vector_out <= next_vec;
                    idx        <= '0;
                    state      <= EMIT;
                    vec_count  <= vec_count + CNT_W'(1);
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_layernorm_input_packer.sv
// tb_layernorm_input_packer: randomized directed sequence checked against a queue-based vector model
module tb_layernorm_input_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_ready;
    logic [15:0] s_data = '0;
    logic s_last = 1'b0;
    logic flush = 1'b0;
    logic valid_out;
    logic [255:0] vector_out;
    logic [15:0] vec_count;
    logic busy;
    logic err_last_early;
    logic err_last_missing;

    logic [15:0] q [$];
    logic [255:0] exp_vec = '0;
    logic [15:0] exp_cnt = '0;
    bit exp_pulse, exp_early, exp_missing;
    int passed = 0;
    int total = 0;
    int pulses = 0;

    layernorm_input_packer dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .flush(flush), .valid_out(valid_out),
        .vector_out(vector_out), .vec_count(vec_count), .busy(busy),
        .err_last_early(err_last_early), .err_last_missing(err_last_missing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input bit v, input logic [15:0] d, input bit l, input bit f, input bit r);
        bit early, missing;
        @(negedge clk);
        s_valid = v; s_data = d; s_last = l; flush = f; rst_n = r;
        #1 chk("s_ready", 256'(s_ready), 256'(r && !f));
        @(posedge clk);
        exp_pulse = 0;
        early = 0;
        missing = 0;
`ifdef LN_PACK_LAST_CHECK_EN
        early = l && q.size() < 15;
        missing = !l;
`endif
        if (!r) begin
            q.delete(); exp_vec = '0; exp_cnt = '0; exp_early = 0; exp_missing = 0;
        end else if (f) begin
            q.delete();
        end else if (v) begin
            if (early) begin
                exp_early = 1;
                q.delete();
            end else begin
                q.push_back(d);
                if (q.size() == 16) begin
                    for (int i = 0; i < 16; i++) exp_vec[16*i +: 16] = q[i];
                    exp_pulse = 1;
                    exp_cnt++;
                    if (missing) exp_missing = 1;
                    q.delete();
                end
            end
        end
        #1;
        if (valid_out) pulses++;
        chk("valid_out", 256'(valid_out), 256'(exp_pulse));
        chk("vector_out", vector_out, exp_vec);
        chk("vec_count", 256'(vec_count), 256'(exp_cnt));
        chk("busy", 256'(busy), 256'(q.size() != 0));
        chk("err_last_early", 256'(err_last_early), 256'(exp_early));
        chk("err_last_missing", 256'(err_last_missing), 256'(exp_missing));
    endtask

    // kind: 0 random data, 1 ramp from 0x0400, 2 constant 0xFC00; framed drives s_last on each 16th element
    task automatic burst(input int n, input int kind, input bit framed, input bit gaps);
        logic [15:0] d;
        int i;
        bit v;
        i = 0;
        while (i < n) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = kind == 1 ? 16'(16'h0400 + i * 16'h0100) : kind == 2 ? 16'hFC00 : 16'($urandom);
            step(v, d, framed && q.size() == 15, 0, 1);
            if (v) i++;
        end
    endtask

    initial begin
        int p0;
        step(0, 0, 0, 0, 0);
        step(1, 16'h1234, 0, 0, 0);
        p0 = pulses;
        burst(16, 1, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("ramp_elem0", 256'(vector_out[15:0]), 256'(16'h0400));
        chk("ramp_elem15", 256'(vector_out[255:240]), 256'(16'h1300));
        chk("ramp_pulses", 256'(pulses - p0), 256'(1));
        p0 = pulses;
        burst(48, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("b2b_pulses", 256'(pulses - p0), 256'(3));
        burst(7, 0, 1, 0);
        step(1, 16'h5555, 0, 1, 1);
        p0 = pulses;
        burst(16, 2, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("flush_pulses", 256'(pulses - p0), 256'(1));
        burst(10, 0, 1, 0);
        step(1, 16'hAAAA, 0, 0, 0);
        step(1, 16'hBBBB, 0, 0, 0);
        burst(16, 0, 1, 0);
        step(0, 0, 0, 0, 1);
        chk("rst_count", 256'(vec_count), 256'(1));
        p0 = pulses;
        burst(15, 0, 1, 0);
        step(1, 16'h7777, 1, 1, 1);
        step(0, 0, 0, 0, 1);
        chk("flush16_pulses", 256'(pulses - p0), 256'(0));
        burst(16, 0, 1, 0);
        step(1, 16'h0101, 0, 1, 1);
        burst(40, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        burst(4, 0, 0, 0);
        step(1, 16'h0505, 1, 0, 1);
        burst(16, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
